// File: rtl/game_ctrl.sv
// game_ctrl: round controller for the factorization game.
// Debounces the start button, hands READY_1P to the ready stage, latches the
// question, runs the answer countdown and keeps score / miss counts.
// Optional feature macro: GAME_TIMEOUT_EN enables the PLAY countdown and DRAW.
//
//   state | meaning
//   IDLE  | waiting for a start press
//   READY | READY_1P issued, waiting for OK from the ready stage
//   PLAY  | question shown, waiting for a judge (or the countdown)
//   DRAW  | countdown expired, result held for HOLD_SEC
//   GOOD  | correct answer, result held for HOLD_SEC
//   OUCH  | wrong answer, result held for HOLD_SEC
//   WIN   | WIN_SCORE reached, terminal until start
//   LOSE  | LOSE_MISS reached, terminal until start
module game_ctrl #(
   parameter int DEB_DIV   = 50_000,
   parameter int TICK_DIV  = 50_000_000,
   parameter int TIME_LIM  = 9,
   parameter int HOLD_SEC  = 2,
   parameter int WIN_SCORE = 3,
   parameter int LOSE_MISS = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN_START,
   input  logic       OK,
   input  logic [3:0] NUM,
   input  logic       JUDGE_VALID,
   input  logic       JUDGE_CORRECT,
   output logic       READY_1P,
   output logic [3:0] STATE,
   output logic [3:0] Q_NUM,
   output logic [3:0] SCORE,
   output logic [3:0] MISS,
   output logic [3:0] SEC_LEFT
);

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0000,
      ST_READY = 4'b0001,
      ST_PLAY  = 4'b0010,
      ST_DRAW  = 4'b0110,
      ST_GOOD  = 4'b1000,
      ST_OUCH  = 4'b1001,
      ST_WIN   = 4'b1010,
      ST_LOSE  = 4'b1011
   } state_e;

   localparam int DEB_W  = $clog2(DEB_DIV + 1);
   localparam int TICK_W = $clog2(TICK_DIV + 1);
`ifdef GAME_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif
   localparam logic [3:0] SEC_LOAD = TIMEOUT_EN ? 4'(TIME_LIM) : 4'd0;

   logic              sync1_q, sync2_q;
   logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
   logic [1:0]        deb_run_q, deb_run_d;
   logic              deb_lvl_q, deb_lvl_d;
   logic              deb_prev_q;
   logic              start_p;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic              tick;
   state_e            state_q, state_d;
   logic              ready_q, ready_d;
   logic [3:0]        q_num_q, q_num_d;
   logic [3:0]        score_q, score_d;
   logic [3:0]        miss_q, miss_d;
   logic [3:0]        sec_q, sec_d;
   logic [3:0]        hold_q, hold_d;

   assign start_p = deb_lvl_q & ~deb_prev_q;
   assign tick    = (tick_cnt_q == '0);

   // debouncer: the level flips after three consecutive samples that disagree with it
   always_comb begin
      deb_cnt_d = deb_cnt_q - DEB_W'(1);
      deb_run_d = deb_run_q;
      deb_lvl_d = deb_lvl_q;
      if (deb_cnt_q == '0) begin
         deb_cnt_d = DEB_W'(DEB_DIV - 1);
         if (sync2_q == deb_lvl_q) begin
            deb_run_d = 2'd0;
         end else if (deb_run_q == 2'd2) begin
            deb_run_d = 2'd0;
            deb_lvl_d = sync2_q;
         end else begin
            deb_run_d = deb_run_q + 2'd1;
         end
      end
   end

   // second divider, restarted on entry to any timed state so the first second is full
   always_comb begin
      tick_cnt_d = tick ? TICK_W'(TICK_DIV - 1) : tick_cnt_q - TICK_W'(1);
      if ((state_d != state_q) &&
          (state_d inside {ST_PLAY, ST_DRAW, ST_GOOD, ST_OUCH}))
         tick_cnt_d = TICK_W'(TICK_DIV - 1);
   end

   // round FSM next-state and counter updates
   always_comb begin
      state_d = state_q;
      ready_d = 1'b0;
      q_num_d = q_num_q;
      score_d = score_q;
      miss_d  = miss_q;
      sec_d   = sec_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (start_p) begin
               state_d = ST_READY;
               ready_d = 1'b1;
            end
         end
         ST_READY: begin
            if (OK) begin
               state_d = ST_PLAY;
               q_num_d = NUM;
               sec_d   = SEC_LOAD;
            end
         end
         ST_PLAY: begin
            // a judge in the same cycle as the final tick wins; SEC_LEFT keeps its value
            if (JUDGE_VALID) begin
               hold_d = 4'(HOLD_SEC);
               if (JUDGE_CORRECT) begin
                  state_d = ST_GOOD;
                  score_d = (score_q == 4'hF) ? score_q : score_q + 4'd1;
               end else begin
                  state_d = ST_OUCH;
                  miss_d  = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;
               end
            end
`ifdef GAME_TIMEOUT_EN
            else if (tick) begin
               sec_d = sec_q - 4'd1;
               if (sec_q == 4'd1) begin
                  state_d = ST_DRAW;
                  hold_d  = 4'(HOLD_SEC);
               end
            end
`endif
         end
         ST_DRAW, ST_GOOD, ST_OUCH: begin
            if (tick) begin
               hold_d = hold_q - 4'd1;
               if (hold_q == 4'd1) begin
                  if ((state_q == ST_GOOD) && (score_q == 4'(WIN_SCORE)))
                     state_d = ST_WIN;
                  else if ((state_q == ST_OUCH) && (miss_q == 4'(LOSE_MISS)))
                     state_d = ST_LOSE;
                  else
                     state_d = ST_IDLE;
               end
            end
         end
         ST_WIN, ST_LOSE: begin
            if (start_p) begin
               state_d = ST_IDLE;
               q_num_d = 4'd0;
               score_d = 4'd0;
               miss_d  = 4'd0;
               sec_d   = 4'd0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // all state registers, synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         deb_cnt_q  <= DEB_W'(DEB_DIV - 1);
         deb_run_q  <= 2'd0;
         deb_lvl_q  <= 1'b0;
         deb_prev_q <= 1'b0;
         tick_cnt_q <= TICK_W'(TICK_DIV - 1);
         state_q    <= ST_IDLE;
         ready_q    <= 1'b0;
         q_num_q    <= 4'd0;
         score_q    <= 4'd0;
         miss_q     <= 4'd0;
         sec_q      <= 4'd0;
         hold_q     <= 4'd0;
      end else begin
         sync1_q    <= BTN_START;
         sync2_q    <= sync1_q;
         deb_cnt_q  <= deb_cnt_d;
         deb_run_q  <= deb_run_d;
         deb_lvl_q  <= deb_lvl_d;
         deb_prev_q <= deb_lvl_q;
         tick_cnt_q <= tick_cnt_d;
         state_q    <= state_d;
         ready_q    <= ready_d;
         q_num_q    <= q_num_d;
         score_q    <= score_d;
         miss_q     <= miss_d;
         sec_q      <= sec_d;
         hold_q     <= hold_d;
      end
   end

   assign READY_1P = ready_q;
   assign STATE    = state_q;
   assign Q_NUM    = q_num_q;
   assign SCORE    = score_q;
   assign MISS     = miss_q;
   assign SEC_LEFT = sec_q;

endmodule
